// File: rtl/ycbcr_to_rgb.sv
// ycbcr_to_rgb: three-stage BT.601 studio-range YCbCr -> RGB converter with
// valid/ready handshake on both sides and SOF/EOL sideband carried per pixel.
// Optional feature macro: YCBCR2RGB_SAT_CNT_EN adds a saturating 16-bit
// count of output pixels that had at least one channel clamped.
module ycbcr_to_rgb #(
    parameter int unsigned Y_OFF = 16,
    parameter int unsigned C_OFF = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  y,
    input  logic [7:0]  cb,
    input  logic [7:0]  cr,
    input  logic        in_sof,
    input  logic        in_eol,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        out_sof,
    output logic        out_eol
`ifdef YCBCR2RGB_SAT_CNT_EN
    ,
    output logic [15:0] sat_count
`endif
);

    localparam int unsigned DW = 9;
    localparam int unsigned SW = 20;

    localparam logic signed [SW-1:0] K_Y  = SW'(298);
    localparam logic signed [SW-1:0] K_RV = SW'(409);
    localparam logic signed [SW-1:0] K_GV = SW'(208);
    localparam logic signed [SW-1:0] K_GU = SW'(100);
    localparam logic signed [SW-1:0] K_BU = SW'(516);
    localparam logic signed [SW-1:0] RND  = SW'(128);
    localparam logic signed [SW-1:0] MAXV = SW'(255);

    logic                 v1, v2;
    logic                 ld1, ld2, ld3;
    logic signed [DW-1:0] yd, cbd, crd;
    logic                 sof1, eol1, sof2, eol2;
    logic signed [SW-1:0] sr, sg, sb;
    logic signed [SW-1:0] sr_c, sg_c, sb_c;
    logic signed [SW-1:0] tr_c, tg_c, tb_c;

    // Round-half-up then drop the 8 fractional bits of the fixed-point sum.
    function automatic logic signed [SW-1:0] rnd_shift(input logic signed [SW-1:0] s);
        return (s + RND) >>> 8;
    endfunction

    // Clamp a rounded channel into the 8-bit output range.
    function automatic logic [7:0] clamp8(input logic signed [SW-1:0] t);
        if (t[SW-1]) begin
            return 8'd0;
        end else if (t > MAXV) begin
            return 8'hFF;
        end else begin
            return t[7:0];
        end
    endfunction

    // A stage may load when empty or when the stage after it frees up this cycle.
    assign ld3      = !out_valid || out_ready;
    assign ld2      = !v2 || ld3;
    assign ld1      = !v1 || ld2;
    assign in_ready = ld1;

    // S1: remove black-level and chroma offsets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            yd   <= '0;
            cbd  <= '0;
            crd  <= '0;
            sof1 <= 1'b0;
            eol1 <= 1'b0;
        end else if (ld1) begin
            v1 <= in_valid;
            if (in_valid) begin
                yd   <= DW'({1'b0, y})  - DW'(Y_OFF);
                cbd  <= DW'({1'b0, cb}) - DW'(C_OFF);
                crd  <= DW'({1'b0, cr}) - DW'(C_OFF);
                sof1 <= in_sof;
                eol1 <= in_eol;
            end
        end
    end

    // Matrix products with coefficients scaled by 256.
    always_comb begin
        sr_c = K_Y * SW'(yd) + K_RV * SW'(crd);
        sg_c = K_Y * SW'(yd) - K_GV * SW'(crd) - K_GU * SW'(cbd);
        sb_c = K_Y * SW'(yd) + K_BU * SW'(cbd);
    end

    // S2: register the fixed-point sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            sr   <= '0;
            sg   <= '0;
            sb   <= '0;
            sof2 <= 1'b0;
            eol2 <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                sr   <= sr_c;
                sg   <= sg_c;
                sb   <= sb_c;
                sof2 <= sof1;
                eol2 <= eol1;
            end
        end
    end

    // Rounded channels ahead of clamping.
    always_comb begin
        tr_c = rnd_shift(sr);
        tg_c = rnd_shift(sg);
        tb_c = rnd_shift(sb);
    end

    // S3: clamp and present; data holds whenever no new pixel arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            r         <= '0;
            g         <= '0;
            b         <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else if (ld3) begin
            out_valid <= v2;
            if (v2) begin
                r       <= clamp8(tr_c);
                g       <= clamp8(tg_c);
                b       <= clamp8(tb_c);
                out_sof <= sof2;
                out_eol <= eol2;
            end
        end
    end

`ifdef YCBCR2RGB_SAT_CNT_EN
    logic sat3;
    logic sat_c;

    // True when a rounded channel falls outside 0..255.
    function automatic logic over(input logic signed [SW-1:0] t);
        return t[SW-1] || (t > MAXV);
    endfunction

    // Any channel of the pixel entering S3 needs clamping.
    always_comb begin
        sat_c = over(tr_c) || over(tg_c) || over(tb_c);
    end

    // Clamp flag travels with the pixel held in S3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat3 <= 1'b0;
        end else if (ld3 && v2) begin
            sat3 <= sat_c;
        end
    end

    // Count clamped pixels as they leave, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && sat3 && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule
